// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the Booth product/shift register.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits retired per step for each Booth radix.
    localparam int RADIX2_STEP = 1;
    localparam int RADIX4_STEP = 2;

    // Number of steps needed to retire all multiplier bits.
    function automatic int iter_of(input int width, input int step_bits);
        return width / step_bits;
    endfunction

    // The count must be able to hold ITER itself, so it gets one spare bit.
    function automatic int cnt_w_of(input int width, input int step_bits);
        return $clog2(width / step_bits) + 1;
    endfunction

endpackage

// File: rtl/en_shift_reg.sv
// Enabled register with asynchronous clear, parallel load and an
// arithmetic right shift that pulls new upper bits in from i_hi.
module en_shift_reg #(
    parameter int PW = 65,   // register width
    parameter int HW = 33,   // width of the incoming upper slice
    parameter int SH = 2     // shift distance per enabled cycle
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          i_load,
    input  logic          i_en,
    input  logic [PW-1:0] i_load_val,
    input  logic [HW-1:0] i_hi,
    output logic [PW-1:0] o_q
);

    logic [PW-1:0]   r_q;
    logic signed [PW:0] w_s;
    logic [PW-1:0]   w_shift;

    // The incoming slice replaces the top of the register; the combined word
    // is one bit wider, so sign fill comes from i_hi's MSB.
    assign w_s     = {i_hi, r_q[PW-HW:0]};
    assign w_shift = PW'(w_s >>> SH);

    // Load wins over shift; with neither the register holds.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            r_q <= '0;
        else if (i_load)
            r_q <= i_load_val;
        else if (i_en)
            r_q <= w_shift;
    end

    assign o_q = r_q;

endmodule

// File: rtl/booth_product_reg.sv
// Product/shift register and step sequencer for the iterative Booth multiplier.
// Optional: define BOOTH_PRODUCT_REG_OVF_EN to add the registered ovf output.
module booth_product_reg
    import booth_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int STEP_BITS = RADIX4_STEP
) (
    input  logic                                    clk,
    input  logic                                    clr,
    input  logic                                    start,
    input  logic [WIDTH-1:0]                        multiplier,
    input  logic                                    step_en,
    input  logic                                    abort,
    input  logic [WIDTH:0]                          sum_in,
    output logic [STEP_BITS:0]                      booth_bits,
    output logic [WIDTH-1:0]                        upper,
    output logic [2*WIDTH-1:0]                      product,
    output logic [cnt_w_of(WIDTH, STEP_BITS)-1:0]   count,
    output logic                                    busy,
    output logic                                    done
`ifdef BOOTH_PRODUCT_REG_OVF_EN
    ,
    output logic                                    ovf
`endif
);

    localparam int ITER = iter_of(WIDTH, STEP_BITS);
    localparam int CW   = cnt_w_of(WIDTH, STEP_BITS);
    localparam int PW   = 2 * WIDTH + 1;

    state_t          r_state;
    state_t          w_state_nx;
    logic [CW-1:0]   r_count;
    logic            w_load;
    logic            w_step;
    logic [PW-1:0]   w_p;

    // Multiplier lands in the middle with a zero Booth guard bit below it.
    en_shift_reg #(
        .PW (PW),
        .HW (WIDTH + 1),
        .SH (STEP_BITS)
    ) u_p (
        .clk        (clk),
        .clr        (clr),
        .i_load     (w_load),
        .i_en       (w_step),
        .i_load_val ({{WIDTH{1'b0}}, multiplier, 1'b0}),
        .i_hi       (sum_in),
        .o_q        (w_p)
    );

    // State register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            r_state <= IDLE;
        else
            r_state <= w_state_nx;
    end

    // Next state plus load/step strobes; abort beats step_en, and DONE lasts one cycle.
    always_comb begin
        w_state_nx = r_state;
        w_load     = 1'b0;
        w_step     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load     = 1'b1;
                    w_state_nx = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    w_state_nx = IDLE;
                end else if (step_en) begin
                    w_step = 1'b1;
                    if (r_count == CW'(ITER - 1))
                        w_state_nx = DONE;
                end
            end
            DONE:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    // Completed-step counter; cleared on load, frozen on stall or abort.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            r_count <= '0;
        else if (w_load)
            r_count <= '0;
        else if (w_step)
            r_count <= r_count + CW'(1);
    end

`ifdef BOOTH_PRODUCT_REG_OVF_EN
    logic r_ovf;

    // Result overflows a signed WIDTH value when the high half is not pure sign.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            r_ovf <= 1'b0;
        else if (w_load)
            r_ovf <= 1'b0;
        else if (r_state == DONE)
            r_ovf <= (w_p[2*WIDTH:WIDTH+1] != {WIDTH{w_p[WIDTH]}});
    end

    assign ovf = r_ovf;
`endif

    assign booth_bits = w_p[STEP_BITS:0];
    assign upper      = w_p[2*WIDTH:WIDTH+1];
    assign product    = w_p[2*WIDTH:1];
    assign count      = r_count;
    assign busy       = (r_state == RUN);
    assign done       = (r_state == DONE);

endmodule
